keypad_scan_fifo: RTL and testbench
===================================

KEYPAD_SCAN_FIFO -- requirements
Module: keypad_scan_fifo

Interface
REQ-001 The parameter ROWS SHALL default to 4 and set the number of keypad row inputs (2..8).
REQ-002 The parameter COLS SHALL default to 4 and set the number of keypad column drive outputs (2..8).
REQ-003 The parameter SCAN_CYCLES SHALL default to 1000 and set the column dwell time in clocks (minimum 4).
REQ-004 The parameter DEBOUNCE_CYCLES SHALL default to 10000 (1 ms) and set the stable-press and stable-release time in clocks.
REQ-005 The parameter FIFO_DEPTH SHALL default to 4 and set the key-code buffer depth (power of two, at least 2).
REQ-006 The port clk_10m SHALL be an input, 1 bit wide, and carry the 10 MHz clock.
REQ-007 The port reset SHALL be an input, 1 bit wide, and act as a synchronous, active-low reset.
REQ-008 The port row SHALL be an input, ROWS bits wide, asynchronous, active-high (a key pressed in the driven column).
REQ-009 The port col SHALL be an output, COLS bits wide, one-hot active-high column drive.
REQ-010 The port key_code SHALL be an output, KEY_W = $clog2(ROWS*COLS) bits wide, carrying the code at the FIFO head.
REQ-011 The port key_valid SHALL be an output, 1 bit wide, asserted while the FIFO is non-empty.
REQ-012 The port key_ready SHALL be an input, 1 bit wide; the consumer accepts the head code when key_valid and key_ready are both high.
REQ-013 The port key_held SHALL be an output, 1 bit wide, high while a debounced key is held.
REQ-014 The port overflow SHALL be an output, 1 bit wide, a sticky flag for a dropped key code.
REQ-015 The port clr_ovf SHALL be an input, 1 bit wide, a synchronous clear for overflow.

Function
REQ-016 The row inputs SHALL pass through a 2-flop synchronizer before any use.
REQ-017 The FSM SHALL implement four states: SCAN, DEBOUNCE, HELD and RELEASE.
REQ-018 In SCAN, col SHALL advance one-hot from index 0 up to COLS-1 and wrap to 0, holding each column for SCAN_CYCLES clocks.
REQ-019 In SCAN, the synced row SHALL be sampled on the last dwell cycle; a nonzero sample SHALL latch the column index and the lowest set row index, and the FSM SHALL enter DEBOUNCE with col frozen.
REQ-020 In DEBOUNCE, the FSM SHALL enter HELD once the latched row has read high for DEBOUNCE_CYCLES consecutive clocks; any low cycle SHALL return it to SCAN on the same column with no push.
REQ-021 The HELD entry cycle SHALL push code = col_idx*ROWS + row_idx, and key_valid SHALL rise on the following cycle if the FIFO was empty.
REQ-022 In HELD, the FSM SHALL enter RELEASE when all synced rows read 0; key_held SHALL be 1 exactly in HELD and RELEASE.
REQ-023 In RELEASE, the FSM SHALL return to SCAN after DEBOUNCE_CYCLES consecutive all-zero clocks, starting at column (latched+1) mod COLS; any nonzero row SHALL return it to HELD with no new push.
REQ-024 A held key SHALL produce exactly one push, with no auto-repeat.
REQ-025 The FIFO SHALL pop when key_valid and key_ready are both 1, and key_code SHALL be stable while key_valid=1 and key_ready=0.
REQ-026 A push SHALL be accepted when count<FIFO_DEPTH or a pop occurs in the same cycle; when full with no pop, the code SHALL be dropped and overflow set on the next cycle.
REQ-027 Simultaneous push and pop SHALL leave count unchanged, and an empty FIFO SHALL ignore key_ready.
REQ-028 A clr_ovf coinciding with a drop SHALL leave overflow set (set wins).

Reset
REQ-029 reset=0 SHALL force state=SCAN, col=1 (column 0), all counters to 0, the FIFO empty, key_valid=0, key_code=0, key_held=0 and overflow=0 on the next clk_10m edge.
REQ-030 A reset in any state, including mid-DEBOUNCE or mid-RELEASE, SHALL discard pending keys with no push.

Structure
REQ-031 Package keypad_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-032 The FIFO SHALL be a separate sub-module keypad_code_fifo (parametrised WIDTH, DEPTH), with the FSM, counters and synchronizer in the top.

Verification (ROWS=4, COLS=4, SCAN_CYCLES=8, DEBOUNCE_CYCLES=16, FIFO_DEPTH=4)
REQ-033 Single key: hold row[2] high while col[1] is driven, key_ready=1 -> one key_valid pulse with key_code=6 and key_held high until 16 clocks after release.
REQ-034 Bounce: toggle row[0] on col[3] for 10 clocks and then release -> no push and scan resumes at col[3].
REQ-035 Two rows: press row[1] and row[3] on col[0] together -> key_code=1 pushed once.
REQ-036 Backpressure: key_ready=0 with 5 distinct presses -> 4 codes retained in order, the 5th dropped, overflow=1; clr_ovf then clears it.
REQ-037 Mid-debounce reset: assert reset=0 on the 8th DEBOUNCE clock -> all outputs reset, no push, col=4'b0001.
REQ-038 Full FIFO with push and pop in the same cycle -> the push is accepted, count stays 4, overflow stays 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and default parameters for the keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      StScan,
      StDebounce,
      StHeld,
      StRelease
   } key_state_e;

   localparam int unsigned DEF_ROWS            = 4;
   localparam int unsigned DEF_COLS            = 4;
   localparam int unsigned DEF_SCAN_CYCLES     = 1000;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 10000;
   localparam int unsigned DEF_FIFO_DEPTH      = 4;

endpackage

// File: rtl/keypad_scan_fifo_if.sv
// Valid/ready key-code stream from the scanner to its consumer.
interface keypad_scan_fifo_if #(
   parameter int unsigned KEY_W = $clog2(keypad_pkg::DEF_ROWS * keypad_pkg::DEF_COLS)
) ();
   logic [KEY_W-1:0] key_code;
   logic             key_valid;
   logic             key_ready;

   modport master (output key_code, output key_valid, input key_ready);
   modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_code_fifo.sv
// Small circular FIFO for key codes with a sticky drop flag.
module keypad_code_fifo #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_10m,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_code,
   input  logic             pop_ready,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] head_code,
   output logic             head_valid,
   output logic             overflow
);
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CNTW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [CNTW-1:0]  count_q;
   logic             pop, accept, drop;

   assign head_valid = (count_q != '0);
   assign head_code  = head_valid ? mem[rd_ptr_q] : '0;
   assign pop        = head_valid && pop_ready;
   // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
   assign accept     = push && ((count_q < CNTW'(DEPTH)) || pop);
   assign drop       = push && !accept;

   // Storage write; no reset needed since head_code is gated by head_valid.
   always_ff @(posedge clk_10m) begin
      if (accept) mem[wr_ptr_q] <= push_code;
   end

   // Pointers, occupancy and sticky overflow (a drop beats a clear).
   always_ff @(posedge clk_10m) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
         if (accept && !pop)      count_q <= count_q + CNTW'(1);
         else if (pop && !accept) count_q <= count_q - CNTW'(1);
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end
endmodule

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: column drive, row sync, debounce FSM, code FIFO.
module keypad_scan_fifo
   import keypad_pkg::*;
#(
   parameter int unsigned ROWS            = DEF_ROWS,
   parameter int unsigned COLS            = DEF_COLS,
   parameter int unsigned SCAN_CYCLES     = DEF_SCAN_CYCLES,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
   input  logic                clk_10m,
   input  logic                reset,
   input  logic [ROWS-1:0]     row,
   output logic [COLS-1:0]     col,
   keypad_scan_fifo_if.master  key_if,
   output logic                key_held,
   output logic                overflow,
   input  logic                clr_ovf
);
   localparam int unsigned KEY_W = $clog2(ROWS * COLS);
   localparam int unsigned CW    = $clog2(COLS);
   localparam int unsigned RW    = $clog2(ROWS);
   localparam int unsigned DW    = $clog2(SCAN_CYCLES);
   localparam int unsigned BW    = $clog2(DEBOUNCE_CYCLES + 1);

   key_state_e       state_q;
   logic [ROWS-1:0]  row_meta_q, row_sync_q;
   logic [CW-1:0]    col_idx_q, next_col;
   logic [RW-1:0]    row_idx_q, low_row;
   logic [DW-1:0]    dwell_q;
   logic [BW-1:0]    deb_q;
   logic             push_q;
   logic [KEY_W-1:0] push_code;

   assign col       = COLS'(1) << col_idx_q;
   assign next_col  = (col_idx_q == CW'(COLS - 1)) ? '0 : col_idx_q + CW'(1);
   assign push_code = KEY_W'(col_idx_q) * KEY_W'(ROWS) + KEY_W'(row_idx_q);

   // Two-flop synchronizer for the asynchronous row inputs.
   always_ff @(posedge clk_10m) begin
      if (!reset) begin
         row_meta_q <= '0;
         row_sync_q <= '0;
      end else begin
         row_meta_q <= row;
         row_sync_q <= row_meta_q;
      end
   end

   // Lowest set row wins when several rows are pressed together.
   always_comb begin
      low_row = '0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (row_sync_q[i]) low_row = RW'(i);
      end
   end

   // Scan/debounce/hold/release FSM; push_q fires on the HELD entry cycle only.
   always_ff @(posedge clk_10m) begin
      if (!reset) begin
         state_q   <= StScan;
         col_idx_q <= '0;
         row_idx_q <= '0;
         dwell_q   <= '0;
         deb_q     <= '0;
         push_q    <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         push_q <= 1'b0;
         unique case (state_q)
            StScan: begin
               if (dwell_q == DW'(SCAN_CYCLES - 1)) begin
                  dwell_q <= '0;
                  if (row_sync_q != '0) begin
                     row_idx_q <= low_row;
                     deb_q     <= '0;
                     state_q   <= StDebounce;
                  end else begin
                     col_idx_q <= next_col;
                  end
               end else begin
                  dwell_q <= dwell_q + DW'(1);
               end
            end
            StDebounce: begin
               // A single low cycle aborts; scanning resumes on the same column.
               if (!row_sync_q[row_idx_q]) begin
                  state_q <= StScan;
               end else if (deb_q == BW'(DEBOUNCE_CYCLES - 1)) begin
                  state_q  <= StHeld;
                  push_q   <= 1'b1;
                  key_held <= 1'b1;
               end else begin
                  deb_q <= deb_q + BW'(1);
               end
            end
            StHeld: begin
               if (row_sync_q == '0) begin
                  deb_q   <= '0;
                  state_q <= StRelease;
               end
            end
            StRelease: begin
               if (row_sync_q != '0) begin
                  state_q <= StHeld;
               end else if (deb_q == BW'(DEBOUNCE_CYCLES - 1)) begin
                  state_q   <= StScan;
                  col_idx_q <= next_col;
                  dwell_q   <= '0;
                  key_held  <= 1'b0;
               end else begin
                  deb_q <= deb_q + BW'(1);
               end
            end
            default: state_q <= StScan;
         endcase
      end
   end

   keypad_code_fifo #(
      .WIDTH (KEY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_10m    (clk_10m),
      .reset      (reset),
      .push       (push_q),
      .push_code  (push_code),
      .pop_ready  (key_if.key_ready),
      .clr_ovf    (clr_ovf),
      .head_code  (key_if.key_code),
      .head_valid (key_if.key_valid),
      .overflow   (overflow)
   );
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo with a 4x4 matrix keypad model.
module tb_keypad_scan_fifo;
   logic        clk_10m = 1'b0;
   logic        reset;
   logic        clr_ovf;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        key_held;
   logic        overflow;
   logic [15:0] keys;   // bit index = col*4 + row = expected key code
   int          checks = 0;
   int          errors = 0;

   keypad_scan_fifo_if #(.KEY_W(4)) key_if ();

   keypad_scan_fifo #(
      .ROWS            (4),
      .COLS            (4),
      .SCAN_CYCLES     (8),
      .DEBOUNCE_CYCLES (16),
      .FIFO_DEPTH      (4)
   ) dut (
      .clk_10m  (clk_10m),
      .reset    (reset),
      .row      (row),
      .col      (col),
      .key_if   (key_if),
      .key_held (key_held),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   always #5 clk_10m = ~clk_10m;

   // Pressed switches connect the driven column to their row line.
   always_comb begin
      row = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (keys[c*4+r] && col[c]) row[r] = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk_10m);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      keys = '0;
      clr_ovf = 1'b0;
      key_if.key_ready = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic wait_held(input logic level, input string name);
      int n = 0;
      while (key_held !== level && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (key_held !== level) begin
         errors++;
         $display("FAIL %s: key_held=%b required %b within 300 clocks", name, key_held, level);
      end
   endtask

   task automatic press_key(input int code);
      keys = '0;
      keys[code] = 1'b1;
      wait_held(1'b1, "press_held");
      keys = '0;
      wait_held(1'b0, "release_held");
   endtask

   task automatic test_reset();
      reset = 1'b0;
      keys = '0;
      clr_ovf = 1'b0;
      key_if.key_ready = 1'b0;
      tick();
      checks++; if (col !== 4'b0001) begin errors++; $display("FAIL rst_col: got %b required 0001", col); end
      checks++; if (key_if.key_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", key_if.key_valid); end
      checks++; if (key_if.key_code !== 4'd0) begin errors++; $display("FAIL rst_code: got %0d required 0", key_if.key_code); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rst_held: got %b required 0", key_held); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b required 0", overflow); end
      reset = 1'b1;
      repeat (7) tick();
      checks++; if (col !== 4'b0001) begin errors++; $display("FAIL dwell_c0: got %b required 0001", col); end
      tick();
      checks++; if (col !== 4'b0010) begin errors++; $display("FAIL dwell_c1: got %b required 0010", col); end
   endtask

   task automatic test_single_key();
      apply_reset();
      keys[6] = 1'b1;
      key_if.key_ready = 1'b1;
      repeat (31) tick();
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL single_early_held: got %b required 0", key_held); end
      tick();
      checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL single_held: got %b required 1", key_held); end
      checks++; if (key_if.key_valid !== 1'b0) begin errors++; $display("FAIL single_valid_lat: got %b required 0", key_if.key_valid); end
      checks++; if (col !== 4'b0010) begin errors++; $display("FAIL single_col_frozen: got %b required 0010", col); end
      tick();
      checks++; if (key_if.key_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b required 1", key_if.key_valid); end
      checks++; if (key_if.key_code !== 4'd6) begin errors++; $display("FAIL single_code: got %0d required 6", key_if.key_code); end
      tick();
      checks++; if (key_if.key_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b required 0", key_if.key_valid); end
      keys = '0;
      repeat (18) tick();
      checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL release_held: got %b required 1", key_held); end
      tick();
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_done: got %b required 0", key_held); end
      checks++; if (col !== 4'b0100) begin errors++; $display("FAIL release_next_col: got %b required 0100", col); end
      checks++; if (key_if.key_valid !== 1'b0) begin errors++; $display("FAIL single_no_repeat: got %b required 0", key_if.key_valid); end
   endtask

   task automatic test_bounce();
      int n = 0;
      int seen = 0;
      apply_reset();
      keys[12] = 1'b1;
      while (col !== 4'b1000 && n < 100) begin tick(); n++; end
      checks++; if (col !== 4'b1000) begin errors++; $display("FAIL bounce_reach_c3: got %b required 1000", col); end
      repeat (10) tick();
      for (int i = 0; i < 10; i++) begin
         keys[12] = i[0];
         tick();
         if (key_held === 1'b1 || key_if.key_valid === 1'b1) seen++;
      end
      keys = '0;
      checks++; if (col !== 4'b1000) begin errors++; $display("FAIL bounce_col_kept: got %b required 1000", col); end
      tick();
      checks++; if (col !== 4'b0001) begin errors++; $display("FAIL bounce_wrap: got %b required 0001", col); end
      repeat (40) begin
         tick();
         if (key_held === 1'b1 || key_if.key_valid === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL bounce_no_push: got %0d active cycles required 0", seen); end
   endtask

   task automatic test_two_rows();
      int n = 0;
      int pulses = 0;
      apply_reset();
      keys[1] = 1'b1;
      keys[3] = 1'b1;
      key_if.key_ready = 1'b1;
      while (key_if.key_valid !== 1'b1 && n < 200) begin tick(); n++; end
      checks++; if (key_if.key_valid !== 1'b1) begin errors++; $display("FAIL two_rows_valid: got %b required 1", key_if.key_valid); end
      checks++; if (key_if.key_code !== 4'd1) begin errors++; $display("FAIL two_rows_code: got %0d required 1", key_if.key_code); end
      repeat (40) begin
         tick();
         if (key_if.key_valid === 1'b1) pulses++;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL two_rows_once: got %0d extra valid cycles required 0", pulses); end
      keys = '0;
      wait_held(1'b0, "two_rows_release");
   endtask

   task automatic test_backpressure();
      logic [3:0] exp [4];
      logic [3:0] first;
      exp = '{4'd0, 4'd5, 4'd10, 4'd15};
      apply_reset();
      for (int i = 0; i < 4; i++) press_key(int'(exp[i]));
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf_early: got %b required 0", overflow); end
      press_key(3);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_set: got %b required 1", overflow); end
      first = key_if.key_code;
      repeat (3) tick();
      checks++; if (key_if.key_code !== 4'd0 || first !== 4'd0) begin errors++; $display("FAIL bp_head_stable: got %0d/%0d required 0/0", first, key_if.key_code); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (key_if.key_valid !== 1'b1 || key_if.key_code !== exp[i]) begin
            errors++;
            $display("FAIL bp_drain_%0d: got valid=%b code=%0d required valid=1 code=%0d", i, key_if.key_valid, key_if.key_code, exp[i]);
         end
         key_if.key_ready = 1'b1;
         tick();
         key_if.key_ready = 1'b0;
      end
      checks++; if (key_if.key_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b required 0", key_if.key_valid); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky: got %b required 1", overflow); end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf_clear: got %b required 0", overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [3:0] exp [4];
      exp = '{4'd6, 4'd12, 4'd2, 4'd7};
      apply_reset();
      press_key(9);
      press_key(6);
      press_key(12);
      press_key(2);
      checks++; if (key_if.key_code !== 4'd9) begin errors++; $display("FAIL full_head: got %0d required 9", key_if.key_code); end
      keys = '0;
      keys[7] = 1'b1;
      wait_held(1'b1, "full_press");
      key_if.key_ready = 1'b1;   // pop lands on the push cycle
      tick();
      key_if.key_ready = 1'b0;
      keys = '0;
      wait_held(1'b0, "full_release");
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf: got %b required 0", overflow); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (key_if.key_valid !== 1'b1 || key_if.key_code !== exp[i]) begin
            errors++;
            $display("FAIL full_drain_%0d: got valid=%b code=%0d required valid=1 code=%0d", i, key_if.key_valid, key_if.key_code, exp[i]);
         end
         key_if.key_ready = 1'b1;
         tick();
         key_if.key_ready = 1'b0;
      end
      checks++; if (key_if.key_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %b required 0", key_if.key_valid); end
   endtask

   task automatic test_mid_debounce_reset();
      int n = 0;
      int pulses = 0;
      apply_reset();
      press_key(4);
      checks++; if (key_if.key_valid !== 1'b1) begin errors++; $display("FAIL mdr_preload: got %b required 1", key_if.key_valid); end
      keys[0] = 1'b1;
      while (col !== 4'b0001 && n < 100) begin tick(); n++; end
      checks++; if (col !== 4'b0001) begin errors++; $display("FAIL mdr_reach_c0: got %b required 0001", col); end
      repeat (15) tick();
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL mdr_debouncing: got %b required 0", key_held); end
      reset = 1'b0;
      keys = '0;
      tick();
      checks++; if (col !== 4'b0001) begin errors++; $display("FAIL mdr_col: got %b required 0001", col); end
      checks++; if (key_if.key_valid !== 1'b0 || key_if.key_code !== 4'd0) begin errors++; $display("FAIL mdr_fifo: got valid=%b code=%0d required 0/0", key_if.key_valid, key_if.key_code); end
      checks++; if (key_held !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL mdr_flags: got held=%b ovf=%b required 0/0", key_held, overflow); end
      reset = 1'b1;
      repeat (60) begin
         tick();
         if (key_if.key_valid === 1'b1 || key_held === 1'b1) pulses++;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL mdr_no_push: got %0d active cycles required 0", pulses); end
   endtask

   initial begin
      keys = '0;
      test_reset();
      test_single_key();
      test_bounce();
      test_two_rows();
      test_backpressure();
      test_full_push_pop();
      test_mid_debounce_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
